// File: rtl/router_input_port_if.sv
// Upstream send/ready link plus the allocator/crossbar side of one router input port.
// Handshake: a packet on di transfers on the rising edge where si && ri; ri never depends on si.
// req is a one-hot offer {N,S,E,W,PE}; a grant on an edge where req != 0 consumes the offered packet.
interface router_input_port_if #(
  parameter int PACKET_WIDTH = 64
);
  logic                    si;
  logic                    ri;
  logic [0:PACKET_WIDTH-1] di;
  logic [0:4]              req;
  logic                    grant;
  logic [0:PACKET_WIDTH-1] dout;

  modport master (output si, di, grant, input ri, req, dout);
  modport slave  (input si, di, grant, output ri, req, dout);
endinterface

// File: rtl/router_input_port.sv
// Two-VC input buffer with XY route computation; the external side writes VC[polarity]
// while the internal side offers VC[~polarity] to the switch allocator.
module router_input_port #(
  parameter int PACKET_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               polarity,
  router_input_port_if.slave bus
);

  logic [1:0]              valid_q, valid_d;
  logic [0:PACKET_WIDTH-1] data_q [2];
  logic [0:PACKET_WIDTH-1] data_d [2];

  logic                    wr_vc, rd_vc;
  logic                    ri;
  logic [0:PACKET_WIDTH-1] head;
  logic [3:0]              hop_x, hop_y;
  logic [0:4]              req;
  logic [0:PACKET_WIDTH-1] dout;

  assign wr_vc = polarity;
  assign rd_vc = ~polarity;
  assign ri    = ~valid_q[wr_vc];
  assign head  = data_q[rd_vc];
  assign hop_x = head[8:11];
  assign hop_y = head[12:15];

  // X is exhausted before Y; the consumed hop field is decremented on the way out.
  always_comb begin
    req  = '0;
    dout = head;
    if (valid_q[rd_vc]) begin
      dout[0] = ~rd_vc;
      if (hop_x != 4'd0) begin
        if (head[1]) req[3] = 1'b1;
        else         req[2] = 1'b1;
        dout[8:11] = hop_x - 4'd1;
      end else if (hop_y != 4'd0) begin
        if (head[2]) req[1] = 1'b1;
        else         req[0] = 1'b1;
        dout[12:15] = hop_y - 4'd1;
      end else begin
        req[4] = 1'b1;
      end
    end
  end

  // Write and drain always address opposite VCs, so they never collide.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (bus.si && ri) begin
      data_d[wr_vc]  = bus.di;
      valid_d[wr_vc] = 1'b1;
    end
    if (bus.grant && valid_q[rd_vc]) begin
      valid_d[rd_vc] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.ri   = ri;
  assign bus.req  = req;
  assign bus.dout = dout;

endmodule

// File: tb/tb_router_input_port.sv
// Bench for router_input_port: directed scenarios plus randomized traffic against a
// per-VC packet-slot model with a route function computed from the header rules.
module tb_router_input_port;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pol = 1'b0;

  router_input_port_if #(.PACKET_WIDTH(W)) bus_if ();

  router_input_port #(.PACKET_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (pol),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: each VC is a single packet slot (occupied flag + contents).
  bit             m_full [2] = '{0, 0};
  logic [0:W-1]   m_pkt  [2] = '{'0, '0};
  logic [W-1:0]   exp_q [$];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Expected crossbar view of a slot: direction index 0..4 = N,S,E,W,PE.
  task automatic route(input logic [0:W-1] pkt, input int q,
                       output logic [0:4] r, output logic [0:W-1] o);
    int hx, hy, idx;
    hx = int'(pkt[8:11]);
    hy = int'(pkt[12:15]);
    o = pkt;
    o[0] = (q == 0);
    if (hx > 0) begin
      idx = pkt[1] ? 3 : 2;
      o[8:11] = 4'(hx - 1);
    end else if (hy > 0) begin
      idx = pkt[2] ? 1 : 0;
      o[12:15] = 4'(hy - 1);
    end else begin
      idx = 4;
    end
    r = 5'b10000 >> idx;
  endtask

  always @(posedge clk) begin
    int p, q;
    bit take, drain;
    p = int'(pol);
    q = 1 - p;
    if (reset) begin
      m_full = '{0, 0};
      m_pkt  = '{'0, '0};
    end else begin
      take  = bus_if.si && !m_full[p];
      drain = bus_if.grant && m_full[q];
      if (take) begin
        m_full[p] = 1;
        m_pkt[p]  = bus_if.di;
      end
      if (drain) m_full[q] = 0;
    end
  end

  always @(negedge clk) begin
    int p, q;
    logic [0:4]   er;
    logic [0:W-1] eo;
    if (!reset) begin
      p = int'(pol);
      q = 1 - p;
      chk("ri", W'(bus_if.ri), W'(!m_full[p]));
      if (m_full[q]) begin
        route(m_pkt[q], q, er, eo);
        exp_q.push_back(W'(er));
        exp_q.push_back(eo);
        chk("req", W'(bus_if.req), exp_q.pop_front());
        chk("dout", bus_if.dout, exp_q.pop_front());
      end else begin
        chk("req_idle", W'(bus_if.req), '0);
      end
    end
  end

  function automatic logic [0:W-1] mk(input bit vc, input bit dx, input bit dy,
                                      input int hx, input int hy);
    logic [0:W-1] p;
    p = {$urandom(), $urandom()};
    p[0] = vc;
    p[1] = dx;
    p[2] = dy;
    p[8:11]  = 4'(hx);
    p[12:15] = 4'(hy);
    return p;
  endfunction

  // Apply inputs for one cycle, then advance to the next cycle with inputs idle.
  task automatic cycle(input bit s, input logic [0:W-1] d, input bit g);
    bus_if.si = s;
    bus_if.di = d;
    bus_if.grant = g;
    @(posedge clk);
    #1;
    pol = ~pol;
    bus_if.si = 1'b0;
    bus_if.grant = 1'b0;
    #1;
  endtask

  task automatic align(input bit p);
    if (pol != p) cycle(0, '0, 0);
  endtask

  logic [0:W-1] pk, pk2, dv;

  initial begin
    bus_if.si = 1'b0;
    bus_if.di = '0;
    bus_if.grant = 1'b0;

    // Reset then idle
    cycle(1, mk(0, 0, 0, 1, 1), 0);
    cycle(0, '0, 0);
    reset = 1'b0;
    chk("rst_ri", W'(bus_if.ri), W'(1));
    chk("rst_req", W'(bus_if.req), '0);
    chk("rst_dout", bus_if.dout, '0);
    cycle(0, '0, 0);
    chk("rst_ri2", W'(bus_if.ri), W'(1));
    chk("rst_dout2", bus_if.dout, '0);

    // Single X hop east
    align(0);
    pk = mk(0, 0, 0, 2, 1);
    cycle(1, pk, 0);
    chk("x_req", W'(bus_if.req), W'(5'b00100));
    dv = bus_if.dout;
    chk("x_hopx", W'(dv[8:11]), W'(1));
    chk("x_hopy", W'(dv[12:15]), W'(1));
    chk("x_vc", W'(dv[0]), W'(1));
    chk("x_payload", W'(dv[16:W-1]), W'(pk[16:W-1]));
    cycle(0, '0, 1);
    chk("x_ri_after", W'(bus_if.ri), W'(1));

    // Y south
    pk = mk(0, 1, 1, 0, 3);
    cycle(1, pk, 0);
    chk("y_req", W'(bus_if.req), W'(5'b01000));
    dv = bus_if.dout;
    chk("y_hopy", W'(dv[12:15]), W'(2));
    cycle(0, '0, 1);

    // Local delivery
    pk = mk(0, 1, 0, 0, 0);
    cycle(1, pk, 0);
    chk("pe_req", W'(bus_if.req), W'(5'b00001));
    dv = bus_if.dout;
    chk("pe_hops", W'(dv[8:15]), W'(8'h00));
    cycle(0, '0, 1);

    // Backpressure: even slot held for 6 cycles, si in even phases ignored
    align(0);
    pk = mk(0, 1, 0, 3, 0);
    cycle(1, pk, 0);
    for (int i = 0; i < 6; i++) begin
      if (pol) begin
        chk("bp_req", W'(bus_if.req), W'(5'b00010));
        dv = bus_if.dout;
        chk("bp_hold", W'(dv[16:W-1]), W'(pk[16:W-1]));
        cycle(0, '0, 0);
      end else begin
        chk("bp_ri", W'(bus_if.ri), W'(0));
        cycle(1, mk(0, 0, 0, 1, 1), 0);
      end
    end
    align(1);
    dv = bus_if.dout;
    chk("bp_final", W'(dv[16:W-1]), W'(pk[16:W-1]));
    cycle(0, '0, 1);
    chk("bp_ri_back", W'(bus_if.ri), W'(1));

    // Simultaneous fill/drain with both VCs occupied
    align(0);
    pk = mk(0, 0, 0, 1, 0);
    cycle(1, pk, 0);
    pk2 = mk(1, 0, 0, 0, 2);
    cycle(1, pk2, 0);
    chk("sim_ri_even", W'(bus_if.ri), W'(0));
    chk("sim_req_odd", W'(bus_if.req), W'(5'b10000));
    cycle(1, mk(0, 1, 1, 0, 0), 1);
    chk("sim_ri_odd", W'(bus_if.ri), W'(1));
    chk("sim_req_even", W'(bus_if.req), W'(5'b00100));
    pk2 = mk(1, 1, 1, 0, 1);
    cycle(1, pk2, 0);
    chk("sim_new_odd", W'(bus_if.req), W'(5'b01000));
    dv = bus_if.dout;
    chk("sim_new_pay", W'(dv[16:W-1]), W'(pk2[16:W-1]));

    // Reset mid-operation: both slots full, reset with si
    chk("mid_full_ri", W'(bus_if.ri), W'(0));
    reset = 1'b1;
    cycle(1, mk(0, 0, 0, 2, 2), 0);
    reset = 1'b0;
    chk("mid_ri", W'(bus_if.ri), W'(1));
    chk("mid_req", W'(bus_if.req), '0);
    chk("mid_dout", bus_if.dout, '0);
    cycle(0, '0, 0);
    chk("mid_ri2", W'(bus_if.ri), W'(1));
    chk("mid_req2", W'(bus_if.req), '0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 60,
            mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15),
               $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 15)),
            $urandom_range(0, 99) < 45);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        cycle(1, mk(0, 0, 0, 1, 1), 0);
        reset = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
